// File: rtl/vga_timing_pkg.sv
// Standard VGA mode timings and helpers shared by the sync generator and its axis counters.
package vga_timing_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam bit VGA640_H_POL    = 1'b0;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_V_POL    = 1'b0;

  // 800x600 @ 60 Hz (40 MHz pixel clock), positive syncs
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam bit VGA800_H_POL    = 1'b1;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;
  localparam bit VGA800_V_POL    = 1'b1;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the pixel pipeline; the consumer owns the run enable.
interface vga_sync_gen_if #(
  parameter int CNT_W = 10
);
  logic             en;
  logic             pixel_tick;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic             h_line_end;
  logic             v_frame_end;
  logic             frame_start;

  modport master (
    input  en,
    output pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on,
           h_line_end, v_frame_end, frame_start
  );

  modport slave (
    output en,
    input  pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on,
           h_line_end, v_frame_end, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus registered sync-window and active-region decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = VGA640_H_ACTIVE,
  parameter int FP     = VGA640_H_FP,
  parameter int SYNC   = VGA640_H_SYNC,
  parameter int BP     = VGA640_H_BP,
  parameter bit POL    = VGA640_H_POL,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             at_end,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam int               TOTAL       = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_STOP   = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] ACTIVE_STOP = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] count_next;
  logic             sync_next;

  assign at_end = (count == LAST);
  assign wrap   = advance && at_end;

  // Explicit compare-then-wrap so the period never depends on CNT_W overflow.
  always_comb begin
    count_next = count;
    if (advance) count_next = at_end ? '0 : count + CNT_W'(1);
  end

  assign sync_next = (count_next >= SYNC_START) && (count_next < SYNC_STOP);

  // Decodes are taken from the next count so they line up with the count they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      sync   <= ~POL;
      active <= 1'b1;
    end else begin
      count  <= count_next;
      sync   <= sync_next ? POL : ~POL;
      active <= (count_next < ACTIVE_STOP);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider driving horizontal and vertical axis counters.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit H_POL    = VGA640_H_POL,
  parameter bit V_POL    = VGA640_V_POL,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  vga_sync_gen_if.master vga
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             run;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic             frame_q;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             h_end, h_wrap, h_sync, h_active;
  logic             v_end, v_wrap, v_sync, v_active;

  // The first edge after reset release only arms the divider, so the first
  // tick lands CLK_DIV cycles after release for every divide ratio.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run     <= 1'b0;
      div     <= '0;
      frame_q <= 1'b0;
    end else begin
      run     <= 1'b1;
      if (vga.en && run) div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      frame_q <= v_wrap;
    end
  end

  assign tick = vga.en && run && (div == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (tick),
    .count   (x),
    .at_end  (h_end),
    .wrap    (h_wrap),
    .sync    (h_sync),
    .active  (h_active)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (h_wrap),
    .count   (y),
    .at_end  (v_end),
    .wrap    (v_wrap),
    .sync    (v_sync),
    .active  (v_active)
  );

  assign vga.pixel_tick  = tick;
  assign vga.pixel_x     = x;
  assign vga.pixel_y     = y;
  assign vga.hsync       = h_sync;
  assign vga.vsync       = v_sync;
  assign vga.video_on    = h_active && v_active;
  assign vga.h_line_end  = h_end;
  assign vga.v_frame_end = h_end && v_end;
  assign vga.frame_start = frame_q && vga.en;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 at /2, positive-sync at /1, and a tiny 15x8 mode at /3 for frame-level checks.
module tb_vga_sync_gen;

  localparam int W = 10;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   fs_c    = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if #(.CNT_W(W)) bus_a ();
  vga_sync_gen_if #(.CNT_W(W)) bus_b ();
  vga_sync_gen_if #(.CNT_W(W)) bus_c ();

  vga_sync_gen #(.CLK_DIV(2), .CNT_W(W)) dut_a (.clk(clk), .reset_n(reset_n), .vga(bus_a));
  vga_sync_gen #(.H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CNT_W(W)) dut_b (.clk(clk), .reset_n(reset_n), .vga(bus_b));
  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                 .CLK_DIV(3), .CNT_W(W)) dut_c (.clk(clk), .reset_n(reset_n), .vga(bus_c));

  // cyc = rising edges since reset release; samples taken on the falling edge
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (bus_c.frame_start === 1'b1) fs_c++;
    end
  endtask

  task automatic run_to(input int k);
    step(k - cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus_a.en = 1'b1; bus_b.en = 1'b1; bus_c.en = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0; fs_c = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({bus_a.pixel_x, bus_a.pixel_y} !== 20'd0) begin errors++; $display("FAIL reset_a_xy got=%0h want=0", {bus_a.pixel_x, bus_a.pixel_y}); end
    checks++; if ({bus_a.pixel_tick, bus_a.frame_start, bus_a.h_line_end, bus_a.v_frame_end} !== 4'b0000) begin errors++; $display("FAIL reset_a_pulses got=%b want=0000", {bus_a.pixel_tick, bus_a.frame_start, bus_a.h_line_end, bus_a.v_frame_end}); end
    checks++; if ({bus_a.video_on, bus_a.hsync, bus_a.vsync} !== 3'b111) begin errors++; $display("FAIL reset_a_levels got=%b want=111", {bus_a.video_on, bus_a.hsync, bus_a.vsync}); end
    checks++; if ({bus_b.hsync, bus_b.vsync, bus_b.pixel_tick} !== 3'b000) begin errors++; $display("FAIL reset_b_pol got=%b want=000", {bus_b.hsync, bus_b.vsync, bus_b.pixel_tick}); end
  endtask

  task automatic test_first_tick();
    do_reset();
    step(1);
    checks++; if ({bus_a.pixel_tick, bus_a.pixel_x} !== {1'b0, 10'd0}) begin errors++; $display("FAIL tick_a_k1 got=%0h want=0", {bus_a.pixel_tick, bus_a.pixel_x}); end
    checks++; if ({bus_b.pixel_tick, bus_b.pixel_x} !== {1'b1, 10'd0}) begin errors++; $display("FAIL tick_b_k1 got=%0h want=400", {bus_b.pixel_tick, bus_b.pixel_x}); end
    step(1);
    checks++; if ({bus_a.pixel_tick, bus_a.pixel_x} !== {1'b1, 10'd0}) begin errors++; $display("FAIL tick_a_k2 got=%0h want=400", {bus_a.pixel_tick, bus_a.pixel_x}); end
    checks++; if ({bus_b.pixel_tick, bus_b.pixel_x} !== {1'b1, 10'd1}) begin errors++; $display("FAIL tick_b_k2 got=%0h want=401", {bus_b.pixel_tick, bus_b.pixel_x}); end
    step(1);
    checks++; if ({bus_a.pixel_tick, bus_a.pixel_x} !== {1'b0, 10'd1}) begin errors++; $display("FAIL tick_a_k3 got=%0h want=1", {bus_a.pixel_tick, bus_a.pixel_x}); end
  endtask

  task automatic test_h_line();
    do_reset();
    run_to(656);
    checks++; if ({bus_b.pixel_x, bus_b.hsync} !== {10'd655, 1'b0}) begin errors++; $display("FAIL b_hs_655 got=%0h want=%0h", {bus_b.pixel_x, bus_b.hsync}, {10'd655, 1'b0}); end
    run_to(657);
    checks++; if ({bus_b.pixel_x, bus_b.hsync} !== {10'd656, 1'b1}) begin errors++; $display("FAIL b_hs_656 got=%0h want=%0h", {bus_b.pixel_x, bus_b.hsync}, {10'd656, 1'b1}); end
    run_to(752);
    checks++; if ({bus_b.pixel_x, bus_b.hsync} !== {10'd751, 1'b1}) begin errors++; $display("FAIL b_hs_751 got=%0h want=%0h", {bus_b.pixel_x, bus_b.hsync}, {10'd751, 1'b1}); end
    run_to(753);
    checks++; if ({bus_b.pixel_x, bus_b.hsync} !== {10'd752, 1'b0}) begin errors++; $display("FAIL b_hs_752 got=%0h want=%0h", {bus_b.pixel_x, bus_b.hsync}, {10'd752, 1'b0}); end
    run_to(800);
    checks++; if ({bus_b.pixel_x, bus_b.pixel_y, bus_b.h_line_end} !== {10'd799, 10'd0, 1'b1}) begin errors++; $display("FAIL b_line_end got=%0h want=%0h", {bus_b.pixel_x, bus_b.pixel_y, bus_b.h_line_end}, {10'd799, 10'd0, 1'b1}); end
    run_to(801);
    checks++; if ({bus_b.pixel_x, bus_b.pixel_y, bus_b.h_line_end, bus_b.vsync} !== {10'd0, 10'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL b_wrap got=%0h want=%0h", {bus_b.pixel_x, bus_b.pixel_y, bus_b.h_line_end, bus_b.vsync}, {10'd0, 10'd1, 2'b00}); end
    run_to(1279);
    checks++; if ({bus_a.pixel_x, bus_a.video_on} !== {10'd639, 1'b1}) begin errors++; $display("FAIL a_von_639 got=%0h want=%0h", {bus_a.pixel_x, bus_a.video_on}, {10'd639, 1'b1}); end
    run_to(1281);
    checks++; if ({bus_a.pixel_x, bus_a.pixel_y, bus_a.video_on} !== {10'd640, 10'd0, 1'b0}) begin errors++; $display("FAIL a_von_640 got=%0h want=%0h", {bus_a.pixel_x, bus_a.pixel_y, bus_a.video_on}, {10'd640, 10'd0, 1'b0}); end
    run_to(1311);
    checks++; if ({bus_a.pixel_x, bus_a.hsync} !== {10'd655, 1'b1}) begin errors++; $display("FAIL a_hs_655 got=%0h want=%0h", {bus_a.pixel_x, bus_a.hsync}, {10'd655, 1'b1}); end
    run_to(1313);
    checks++; if ({bus_a.pixel_x, bus_a.hsync} !== {10'd656, 1'b0}) begin errors++; $display("FAIL a_hs_656 got=%0h want=%0h", {bus_a.pixel_x, bus_a.hsync}, {10'd656, 1'b0}); end
    run_to(1503);
    checks++; if ({bus_a.pixel_x, bus_a.hsync} !== {10'd751, 1'b0}) begin errors++; $display("FAIL a_hs_751 got=%0h want=%0h", {bus_a.pixel_x, bus_a.hsync}, {10'd751, 1'b0}); end
    run_to(1505);
    checks++; if ({bus_a.pixel_x, bus_a.hsync} !== {10'd752, 1'b1}) begin errors++; $display("FAIL a_hs_752 got=%0h want=%0h", {bus_a.pixel_x, bus_a.hsync}, {10'd752, 1'b1}); end
    run_to(1599);
    checks++; if ({bus_a.pixel_x, bus_a.h_line_end, bus_a.pixel_tick} !== {10'd799, 1'b1, 1'b0}) begin errors++; $display("FAIL a_end_k1599 got=%0h want=%0h", {bus_a.pixel_x, bus_a.h_line_end, bus_a.pixel_tick}, {10'd799, 2'b10}); end
    checks++; if ({bus_b.pixel_x, bus_b.h_line_end} !== {10'd798, 1'b0}) begin errors++; $display("FAIL b_end_k1599 got=%0h want=%0h", {bus_b.pixel_x, bus_b.h_line_end}, {10'd798, 1'b0}); end
    run_to(1600);
    checks++; if ({bus_a.pixel_x, bus_a.h_line_end, bus_a.pixel_tick} !== {10'd799, 1'b1, 1'b1}) begin errors++; $display("FAIL a_end_k1600 got=%0h want=%0h", {bus_a.pixel_x, bus_a.h_line_end, bus_a.pixel_tick}, {10'd799, 2'b11}); end
    checks++; if ({bus_b.pixel_x, bus_b.pixel_y, bus_b.h_line_end} !== {10'd799, 10'd1, 1'b1}) begin errors++; $display("FAIL b_end_k1600 got=%0h want=%0h", {bus_b.pixel_x, bus_b.pixel_y, bus_b.h_line_end}, {10'd799, 10'd1, 1'b1}); end
    run_to(1601);
    checks++; if ({bus_a.pixel_x, bus_a.pixel_y, bus_a.h_line_end} !== {10'd0, 10'd1, 1'b0}) begin errors++; $display("FAIL a_wrap got=%0h want=%0h", {bus_a.pixel_x, bus_a.pixel_y, bus_a.h_line_end}, {10'd0, 10'd1, 1'b0}); end
  endtask

  task automatic test_frame();
    do_reset();
    run_to(22);
    checks++; if ({bus_c.pixel_x, bus_c.video_on, bus_c.hsync} !== {10'd7, 2'b11}) begin errors++; $display("FAIL c_von_7_0 got=%0h want=%0h", {bus_c.pixel_x, bus_c.video_on, bus_c.hsync}, {10'd7, 2'b11}); end
    run_to(25);
    checks++; if ({bus_c.pixel_x, bus_c.video_on} !== {10'd8, 1'b0}) begin errors++; $display("FAIL c_von_8_0 got=%0h want=%0h", {bus_c.pixel_x, bus_c.video_on}, {10'd8, 1'b0}); end
    run_to(31);
    checks++; if ({bus_c.pixel_x, bus_c.hsync} !== {10'd10, 1'b0}) begin errors++; $display("FAIL c_hs_10 got=%0h want=%0h", {bus_c.pixel_x, bus_c.hsync}, {10'd10, 1'b0}); end
    run_to(40);
    checks++; if ({bus_c.pixel_x, bus_c.hsync} !== {10'd13, 1'b1}) begin errors++; $display("FAIL c_hs_13 got=%0h want=%0h", {bus_c.pixel_x, bus_c.hsync}, {10'd13, 1'b1}); end
    run_to(157);
    checks++; if ({bus_c.pixel_x, bus_c.pixel_y, bus_c.video_on} !== {10'd7, 10'd3, 1'b1}) begin errors++; $display("FAIL c_von_7_3 got=%0h want=%0h", {bus_c.pixel_x, bus_c.pixel_y, bus_c.video_on}, {10'd7, 10'd3, 1'b1}); end
    run_to(181);
    checks++; if ({bus_c.pixel_x, bus_c.pixel_y, bus_c.video_on} !== {10'd0, 10'd4, 1'b0}) begin errors++; $display("FAIL c_von_0_4 got=%0h want=%0h", {bus_c.pixel_x, bus_c.pixel_y, bus_c.video_on}, {10'd0, 10'd4, 1'b0}); end
    run_to(225);
    checks++; if ({bus_c.pixel_y, bus_c.vsync} !== {10'd4, 1'b1}) begin errors++; $display("FAIL c_vs_y4 got=%0h want=%0h", {bus_c.pixel_y, bus_c.vsync}, {10'd4, 1'b1}); end
    run_to(226);
    checks++; if ({bus_c.pixel_y, bus_c.vsync} !== {10'd5, 1'b0}) begin errors++; $display("FAIL c_vs_y5 got=%0h want=%0h", {bus_c.pixel_y, bus_c.vsync}, {10'd5, 1'b0}); end
    run_to(315);
    checks++; if ({bus_c.pixel_y, bus_c.vsync} !== {10'd6, 1'b0}) begin errors++; $display("FAIL c_vs_y6 got=%0h want=%0h", {bus_c.pixel_y, bus_c.vsync}, {10'd6, 1'b0}); end
    run_to(316);
    checks++; if ({bus_c.pixel_y, bus_c.vsync} !== {10'd7, 1'b1}) begin errors++; $display("FAIL c_vs_y7 got=%0h want=%0h", {bus_c.pixel_y, bus_c.vsync}, {10'd7, 1'b1}); end
    run_to(357);
    checks++; if ({bus_c.pixel_x, bus_c.v_frame_end} !== {10'd13, 1'b0}) begin errors++; $display("FAIL c_vfe_13 got=%0h want=%0h", {bus_c.pixel_x, bus_c.v_frame_end}, {10'd13, 1'b0}); end
    run_to(358);
    checks++; if ({bus_c.pixel_x, bus_c.pixel_y, bus_c.h_line_end, bus_c.v_frame_end} !== {10'd14, 10'd7, 2'b11}) begin errors++; $display("FAIL c_vfe_14 got=%0h want=%0h", {bus_c.pixel_x, bus_c.pixel_y, bus_c.h_line_end, bus_c.v_frame_end}, {10'd14, 10'd7, 2'b11}); end
    run_to(360);
    checks++; if ({bus_c.pixel_tick, bus_c.frame_start} !== 2'b10) begin errors++; $display("FAIL c_pre_wrap got=%b want=10", {bus_c.pixel_tick, bus_c.frame_start}); end
    run_to(361);
    checks++; if ({bus_c.pixel_x, bus_c.pixel_y, bus_c.frame_start} !== {10'd0, 10'd0, 1'b1}) begin errors++; $display("FAIL c_fs_1 got=%0h want=1", {bus_c.pixel_x, bus_c.pixel_y, bus_c.frame_start}); end
    run_to(362);
    checks++; if (bus_c.frame_start !== 1'b0) begin errors++; $display("FAIL c_fs_width got=%b want=0", bus_c.frame_start); end
    run_to(720);
    checks++; if (bus_c.frame_start !== 1'b0) begin errors++; $display("FAIL c_fs_early got=%b want=0", bus_c.frame_start); end
    run_to(721);
    checks++; if (bus_c.frame_start !== 1'b1) begin errors++; $display("FAIL c_fs_2 got=%b want=1", bus_c.frame_start); end
    run_to(725);
    checks++; if (fs_c != 2) begin errors++; $display("FAIL c_fs_count got=%0d want=2", fs_c); end
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    do_reset();
    run_to(602);
    checks++; if ({bus_a.pixel_x, bus_a.pixel_tick} !== {10'd300, 1'b1}) begin errors++; $display("FAIL en_pre got=%0h want=%0h", {bus_a.pixel_x, bus_a.pixel_tick}, {10'd300, 1'b1}); end
    bus_a.en = 1'b0;
    #1;
    checks++; if (bus_a.pixel_tick !== 1'b0) begin errors++; $display("FAIL en_tick_suppressed got=%b want=0", bus_a.pixel_tick); end
    for (int i = 0; i < 37; i++) begin
      step(1);
      if (bus_a.pixel_tick !== 1'b0 || bus_a.pixel_x !== 10'd300 || bus_a.hsync !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL en_hold bad_cycles=%0d want=0", bad); end
    checks++; if (bus_a.pixel_x !== 10'd300) begin errors++; $display("FAIL en_x_held got=%0d want=300", bus_a.pixel_x); end
    bus_a.en = 1'b1;
    #1;
    checks++; if (bus_a.pixel_tick !== 1'b1) begin errors++; $display("FAIL en_resume_tick got=%b want=1", bus_a.pixel_tick); end
    step(1);
    checks++; if ({bus_a.pixel_x, bus_a.pixel_tick} !== {10'd301, 1'b0}) begin errors++; $display("FAIL en_resume_x got=%0h want=%0h", {bus_a.pixel_x, bus_a.pixel_tick}, {10'd301, 1'b0}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_to(256);
    checks++; if ({bus_c.pixel_x, bus_c.pixel_y, bus_c.hsync, bus_c.vsync, bus_c.video_on} !== {10'd10, 10'd5, 3'b000}) begin errors++; $display("FAIL mid_pos got=%0h want=%0h", {bus_c.pixel_x, bus_c.pixel_y, bus_c.hsync, bus_c.vsync, bus_c.video_on}, {10'd10, 10'd5, 3'b000}); end
    reset_n = 1'b0;
    #1;
    checks++; if ({bus_c.pixel_x, bus_c.pixel_y} !== 20'd0) begin errors++; $display("FAIL mid_rst_xy got=%0h want=0", {bus_c.pixel_x, bus_c.pixel_y}); end
    checks++; if ({bus_c.hsync, bus_c.vsync, bus_c.video_on, bus_c.pixel_tick, bus_c.frame_start, bus_c.h_line_end, bus_c.v_frame_end} !== 7'b1110000) begin errors++; $display("FAIL mid_rst_flags got=%b want=1110000", {bus_c.hsync, bus_c.vsync, bus_c.video_on, bus_c.pixel_tick, bus_c.frame_start, bus_c.h_line_end, bus_c.v_frame_end}); end
    checks++; if (bus_a.pixel_x !== 10'd0) begin errors++; $display("FAIL mid_rst_a_x got=%0d want=0", bus_a.pixel_x); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0; fs_c = 0;
    run_to(30);
    checks++; if (fs_c != 0) begin errors++; $display("FAIL mid_no_fs got=%0d want=0", fs_c); end
    checks++; if ({bus_c.pixel_x, bus_c.pixel_y} !== {10'd9, 10'd0}) begin errors++; $display("FAIL mid_restart got=%0h want=%0h", {bus_c.pixel_x, bus_c.pixel_y}, {10'd9, 10'd0}); end
  endtask

  initial begin
    bus_a.en = 1'b1; bus_b.en = 1'b1; bus_c.en = 1'b1;
    test_reset();
    test_first_tick();
    test_h_line();
    test_frame();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised VGA timing generator: successor to the single horizontal pixel counter, producing paired horizontal/vertical counters, hsync/vsync with programmable porches and polarity, an active-video flag and frame/line markers. Sits between the system clock and the pixel pipeline/framebuffer reader. Pixel rate is derived from clk by an internal tick divider.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width, back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync width, back porch (lines)
- H_POL / V_POL, 0 / 0, sync polarity during sync pulse (0 = active-low)
- CLK_DIV, 2, clk cycles per pixel (≥1; 1 means tick every cycle)
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- en  in  1  run enable; low freezes divider and counters
- pixel_tick  out  1  one-clk pulse when counters advance
- pixel_x  out  CNT_W  horizontal position, 0..H_TOTAL-1
- pixel_y  out  CNT_W  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- video_on  out  1  high when pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
- h_line_end  out  1  high while pixel_x==H_TOTAL-1
- v_frame_end  out  1  high while pixel_x==H_TOTAL-1 and pixel_y==V_TOTAL-1
- frame_start  out  1  one-clk pulse on the tick that wraps to (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525).
- Divider counts 0..CLK_DIV-1 while en=1; pixel_tick asserted in the cycle the divider is CLK_DIV-1 (every cycle if CLK_DIV=1).
- On each clk edge where pixel_tick=1: pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments; pixel_y wraps from V_TOTAL-1 to 0.
- hsync in sync pulse when H_ACTIVE+H_FP ≤ pixel_x < H_ACTIVE+H_FP+H_SYNC; vsync likewise on pixel_y with V_ constants. Outside pulse: inverted polarity.
- hsync, vsync, video_on are registered, computed from next-state counter values, so they always describe the current pixel_x/pixel_y in the same cycle (no skew).
- en=0: divider, counters and all registered outputs hold; pixel_tick and frame_start are 0.
- Counter arithmetic is unsigned CNT_W-bit; compare-then-wrap, never natural overflow.

## Timing
- Reset values: pixel_x=0, pixel_y=0, divider=0, pixel_tick=0, frame_start=0, video_on=1, hsync=!H_POL, vsync=!V_POL, h_line_end=0, v_frame_end=0.
- First pixel_tick CLK_DIV cycles after reset release with en=1; pixel_x=1 on the following cycle.
- frame_start asserts in the cycle after the wrapping edge (coincident with pixel_x=0, pixel_y=0) for exactly one clk.
- h_line_end/v_frame_end are combinational decodes of registered counters; held for CLK_DIV cycles.
- Reset mid-frame: immediate return to reset values; no frame_start issued.
- en deasserted on the tick cycle: tick is suppressed, counters do not advance.

## Structure
- Package vga_timing_pkg: default 640x480@60 constants (active, porches, sync, polarity) and a function computing totals; 800x600 set as second constant group.
- Sub-module vga_axis_counter (count, wrap, sync-window and active decode) instantiated twice: horizontal (advance on tick) and vertical (advance on tick & horizontal wrap).

## Test plan
- Defaults, CLK_DIV=2: after reset, pixel_x reaches 799 then 0 with pixel_y=1; hsync low exactly for pixel_x 656..751.
- Full frame: frame_start pulses once every 800*525*2=840000 clk; vsync low for pixel_y 490..491.
- video_on high only for x<640 and y<480; checked at (639,479)=1, (640,0)=0, (0,480)=0.
- H_POL=V_POL=1, CLK_DIV=1: sync pulses high, tick every cycle, line period 800 clk.
- en low for 37 clk at pixel_x=300: counters hold at 300, no ticks; resumes at 301 on next tick.
- reset_n asserted at (400,250): outputs immediately at reset values; restart from (0,0) without frame_start.
